// File: rtl/conv_pkg.sv
// Shared types and default geometry for the conv row scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    REFILL,
    DONE
  } sched_state_t;

  // Default geometry: 8-bit pixels, 5x5 kernel, 28x28 output image.
  localparam int N_DEF   = 7;
  localparam int K_DEF   = 5;
  localparam int IM_DEF  = 28;
  localparam int IMG_DEF = IM_DEF + K_DEF - 1;

  localparam int COL_W  = $clog2(IMG_DEF);
  localparam int SLOT_W = $clog2(K_DEF);
  localparam int ROW_W  = $clog2(IM_DEF);

endpackage

// File: rtl/conv_row_sched_raster_cnt.sv
// Modulo-MAX up-counter with synchronous clear and a wrap pulse.
// Wrap is combinational: high on the increment that returns the count to 0.
module raster_cnt #(
  parameter int MAX = 32,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = inc && (cnt_q == LAST);
  assign cnt  = cnt_q;

  // Next count: clear wins over increment; wrap by compare so MAX need not be 2^n.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv_row_sched.sv
// Line-buffer fill/refill sequencer for one conv engine over a padded frame.
//
// state  | meaning
// IDLE   | waiting for start, no requests
// FILL   | loading physical slots 0..K-1 with the first K rows
// RUN    | engine computing one output row, upstream paused
// REFILL | overwriting the oldest slot (row_base) with the next row
// DONE   | one-cycle frame_done, then back to IDLE
module conv_row_sched
  import conv_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int K   = K_DEF,
  parameter int IM  = IM_DEF,
  parameter int IMG = IM + K - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N:0]             data,
  input  logic                   data_valid,
  output logic                   data_request,
  output logic                   buf_we,
  output logic [$clog2(K)-1:0]   buf_row,
  output logic [$clog2(IMG)-1:0] buf_col,
  output logic [N:0]             buf_wdata,
  output logic [$clog2(K)-1:0]   row_base,
  output logic                   conv_start,
  input  logic                   conv_row_done,
  output logic [$clog2(IM)-1:0]  out_row,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   proto_err
);

  localparam int SW = $clog2(K);
  localparam int CW = $clog2(IMG);
  localparam int RW = $clog2(IM);
  localparam logic [RW-1:0] LAST_ROW = RW'(IM - 1);

  sched_state_t  state_q, state_d;
  logic          conv_start_q, conv_start_d;
  logic          proto_err_q, proto_err_d;
  logic          accept, go, eor, fill_eor, refill_eor;
  logic          slot_wrap, rb_wrap, row_wrap;
  logic          unused_wraps;
  logic [SW-1:0] slot, rb;
  logic [RW-1:0] orow;
  logic [CW-1:0] col;

  assign accept     = data_valid && data_request;
  assign go         = (state_q == IDLE) && start;
  assign fill_eor   = (state_q == FILL) && eor;
  assign refill_eor = (state_q == REFILL) && eor;

  // Column position within the row being streamed; wrap marks end-of-row.
  raster_cnt #(.MAX(IMG), .W(CW)) u_col (
    .clk(clk), .reset(reset), .clr(go), .inc(accept), .cnt(col), .wrap(eor)
  );

  // Slot being loaded during FILL; its wrap is the last FILL row completing.
  raster_cnt #(.MAX(K), .W(SW)) u_slot (
    .clk(clk), .reset(reset), .clr(go), .inc(fill_eor), .cnt(slot), .wrap(slot_wrap)
  );

  // Oldest physical slot, advanced after each refill row.
  raster_cnt #(.MAX(K), .W(SW)) u_base (
    .clk(clk), .reset(reset), .clr(go), .inc(refill_eor), .cnt(rb), .wrap(rb_wrap)
  );

  // Output row index; only IM-1 refills happen, so it never wraps in practice.
  raster_cnt #(.MAX(IM), .W(RW)) u_row (
    .clk(clk), .reset(reset), .clr(go), .inc(refill_eor), .cnt(orow), .wrap(row_wrap)
  );

  assign unused_wraps = rb_wrap ^ row_wrap;

  // State and registered pulse/flag outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      conv_start_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_start_q <= conv_start_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (slot_wrap) state_d = RUN;
      RUN:     if (conv_row_done) state_d = (orow == LAST_ROW) ? DONE : REFILL;
      REFILL:  if (eor) state_d = RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; conv_start fires on every entry into RUN.
  always_comb begin
    data_request = (state_q == FILL) || (state_q == REFILL);
    busy         = (state_q != IDLE);
    frame_done   = (state_q == DONE);
    buf_row      = (state_q == REFILL) ? rb : slot;
    conv_start_d = (state_d == RUN) && (state_q != RUN);
    proto_err_d  = proto_err_q;
    if (go) proto_err_d = 1'b0;
    if (conv_row_done && (state_q != RUN)) proto_err_d = 1'b1;
  end

  assign buf_we     = accept;
  assign buf_wdata  = accept ? data : '0;
  assign buf_col    = col;
  assign row_base   = rb;
  assign out_row    = orow;
  assign conv_start = conv_start_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_conv_row_sched.sv
// Scoreboard bench for conv_row_sched: a default-size instance and a small
// K=3/IM=4 instance, exercised one at a time through a shared driver.
module tb_conv_row_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, dv, crd;
  logic [7:0] data;
  bit         sel;

  always #5 clk = ~clk;

  // Default instance: K=5, IM=28, IMG=32
  logic       a_req, a_we, a_cs, a_busy, a_fd, a_pe;
  logic [2:0] a_row, a_rb;
  logic [4:0] a_col, a_orow;
  logic [7:0] a_wdata;

  conv_row_sched #(.N(7), .K(5), .IM(28)) u_dut_a (
    .clk(clk), .reset(reset), .start(start && !sel), .data(data),
    .data_valid(dv && !sel), .data_request(a_req), .buf_we(a_we),
    .buf_row(a_row), .buf_col(a_col), .buf_wdata(a_wdata), .row_base(a_rb),
    .conv_start(a_cs), .conv_row_done(crd && !sel), .out_row(a_orow),
    .busy(a_busy), .frame_done(a_fd), .proto_err(a_pe)
  );

  // Small instance: K=3, IM=4, IMG=6
  logic       b_req, b_we, b_cs, b_busy, b_fd, b_pe;
  logic [1:0] b_row, b_rb, b_orow;
  logic [2:0] b_col;
  logic [7:0] b_wdata;

  conv_row_sched #(.N(7), .K(3), .IM(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start && sel), .data(data),
    .data_valid(dv && sel), .data_request(b_req), .buf_we(b_we),
    .buf_row(b_row), .buf_col(b_col), .buf_wdata(b_wdata), .row_base(b_rb),
    .conv_start(b_cs), .conv_row_done(crd && sel), .out_row(b_orow),
    .busy(b_busy), .frame_done(b_fd), .proto_err(b_pe)
  );

  bit m_req, m_we, m_cs, m_busy, m_fd, m_pe;
  int m_row, m_col, m_wdata, m_rb, m_orow;

  always_comb begin
    m_req   = sel ? b_req   : a_req;
    m_we    = sel ? b_we    : a_we;
    m_cs    = sel ? b_cs    : a_cs;
    m_busy  = sel ? b_busy  : a_busy;
    m_fd    = sel ? b_fd    : a_fd;
    m_pe    = sel ? b_pe    : a_pe;
    m_row   = sel ? int'(b_row)   : int'(a_row);
    m_col   = sel ? int'(b_col)   : int'(a_col);
    m_wdata = sel ? int'(b_wdata) : int'(a_wdata);
    m_rb    = sel ? int'(b_rb)    : int'(a_rb);
    m_orow  = sel ? int'(b_orow)  : int'(a_orow);
  end

  typedef struct {
    int         r;
    int         slot;
    int         col;
    logic [7:0] pix;
  } exp_t;

  exp_t sbq[$];

  int K_m, IM_m, IMG_m, D;
  int p, acc_cnt, cs_cnt, fd_cnt, cd;
  int n_checks, n_fail;
  bit bubbly, coinc, coinc_next, stream_en, have_pix, prev_eor, prev_fd;
  bit kick, inj_start, inj_now, force_crd, abort_en, aborted;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix_of(input int idx);
    return 8'((idx * 37 + 11) & 255);
  endfunction

  // Slot that logical stream row r lands in: rows 0..K-1 fill in order,
  // later rows replace the oldest slot round-robin.
  function automatic int slot_of(input int r);
    return (r < K_m) ? r : (r - K_m) % K_m;
  endfunction

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_req"},   int'(m_req),  0);
    check_eq({pfx, "_we"},    int'(m_we),   0);
    check_eq({pfx, "_row"},   m_row,        0);
    check_eq({pfx, "_col"},   m_col,        0);
    check_eq({pfx, "_wdata"}, m_wdata,      0);
    check_eq({pfx, "_rb"},    m_rb,         0);
    check_eq({pfx, "_cs"},    int'(m_cs),   0);
    check_eq({pfx, "_orow"},  m_orow,       0);
    check_eq({pfx, "_busy"},  int'(m_busy), 0);
    check_eq({pfx, "_fd"},    int'(m_fd),   0);
    check_eq({pfx, "_pe"},    int'(m_pe),   0);
  endtask

  // One clock: drive just after posedge, observe at negedge.
  task automatic step();
    exp_t e;
    bit   acc, eor_win, do_abort;
    @(posedge clk);
    #1;
    crd = force_crd;
    if (cd > 0) begin
      cd--;
      if (cd == 0) crd = 1'b1;
    end
    if (coinc_next) begin
      crd        = 1'b1;
      coinc_next = 1'b0;
    end
    start   = kick || (inj_start && inj_now);
    inj_now = 1'b0;
    if (stream_en && !have_pix && p < IMG_m * IMG_m + 4) begin
      e.r    = p / IMG_m;
      e.col  = p % IMG_m;
      e.slot = slot_of(e.r);
      e.pix  = pix_of(p);
      sbq.push_back(e);
      data     = e.pix;
      have_pix = 1'b1;
      p++;
    end
    dv = stream_en && have_pix && (bubbly ? ($urandom_range(0, 1) == 1) : 1'b1);

    @(negedge clk);
    acc      = dv && m_req;
    eor_win  = 1'b0;
    do_abort = 1'b0;
    if (dv || m_we) check_eq("we_rule", int'(m_we), int'(acc));
    if (m_we) begin
      check_eq("sb_nonempty", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check_eq("buf_row", m_row, e.slot);
        check_eq("buf_col", m_col, e.col);
        check_eq("buf_wdata", m_wdata, int'(e.pix));
        eor_win = (e.col == IMG_m - 1) && (e.r >= K_m - 1);
        if (coinc && e.r == IMG_m - 1 && e.col == IMG_m - 1) coinc_next = 1'b1;
        if (abort_en && e.r == 7 && e.col == 16) do_abort = 1'b1;
      end
      acc_cnt++;
      have_pix = 1'b0;
    end
    if (m_cs || prev_eor) check_eq("cs_latency", int'(m_cs), int'(prev_eor));
    if (m_cs) begin
      check_eq("row_base", m_rb, cs_cnt % K_m);
      check_eq("out_row", m_orow, cs_cnt);
      cs_cnt++;
      if (!(coinc && cs_cnt == IM_m)) cd = D;
      inj_now = (cs_cnt == 3);
    end
    prev_eor = eor_win;
    if (prev_fd) begin
      check_eq("fd_one_cycle", int'(m_fd), 0);
      check_eq("busy_after_done", int'(m_busy), 0);
    end
    if (m_fd) begin
      fd_cnt++;
      check_eq("busy_in_done", int'(m_busy), 1);
    end
    prev_fd = m_fd;
    if (do_abort) begin
      reset   = 1'b0;
      aborted = 1'b1;
    end
  endtask

  task automatic run_frame(input int max_cycles);
    int n;
    sbq.delete();
    p = 0; have_pix = 0; acc_cnt = 0; cs_cnt = 0; fd_cnt = 0;
    prev_eor = 0; prev_fd = 0; cd = 0; coinc_next = 0; aborted = 0;
    stream_en = 1;
    kick = 1;
    step();
    kick = 0;
    step();
    check_eq("pe_cleared", int'(m_pe), 0);
    check_eq("busy_after_start", int'(m_busy), 1);
    n = 0;
    while (fd_cnt == 0 && !aborted && n < max_cycles) begin
      step();
      n++;
    end
    if (aborted) return;
    check_eq("frame_timeout", int'(n < max_cycles), 1);
    repeat (4) step();
    check_eq("accepts", acc_cnt, IMG_m * IMG_m);
    check_eq("conv_starts", cs_cnt, IM_m);
    check_eq("frame_done_pulses", fd_cnt, 1);
    check_eq("pe_end", int'(m_pe), 0);
    stream_en = 0;
    step();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; start = 1'b0; dv = 1'b0; crd = 1'b0; data = 8'hA5; sel = 1'b0;
    K_m = 5; IM_m = 28; IMG_m = 32; D = 10;
    bubbly = 0; coinc = 0; coinc_next = 0; stream_en = 0; have_pix = 0;
    prev_eor = 0; prev_fd = 0; kick = 0; inj_start = 0; inj_now = 0;
    force_crd = 0; abort_en = 0; aborted = 0; cd = 0; p = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    reset = 1'b1;
    step();

    // conv_row_done while idle only raises the error flag
    force_crd = 1;
    step();
    force_crd = 0;
    step();
    check_eq("proto_err_idle", int'(m_pe), 1);
    check_eq("busy_idle", int'(m_busy), 0);

    // Continuous frame, start injected during RUN, last done coincident with conv_start
    coinc = 1; inj_start = 1;
    run_frame(4000);
    coinc = 0; inj_start = 0;

    // Reset in the middle of the refill of stream row 7
    abort_en = 1;
    run_frame(4000);
    check_eq("abort_reached", int'(aborted), 1);
    @(posedge clk);
    #1;
    check_zero("abort");
    abort_en  = 0;
    stream_en = 0;
    dv        = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    // Fresh frame after the abort, normal engine latency on every row
    run_frame(4000);

    // Small geometry with a bubbly upstream
    sel = 1'b1; K_m = 3; IM_m = 4; IMG_m = 6; D = 3; bubbly = 1;
    step();
    run_frame(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
